// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared address map, FIFO sizing and STATUS bit layout for
// the data-memory / MMIO slave. Optional feature macro: DMEM_MMIO_CYCLE_EN.
package dmem_mmio_pkg;

  // Address map
  localparam logic [7:0] RAM_TOP     = 8'hEF;
  localparam logic [7:0] ADDR_GPIO   = 8'hF0;
  localparam logic [7:0] ADDR_TXDATA = 8'hF1;
  localparam logic [7:0] ADDR_STATUS = 8'hF2;
  localparam logic [7:0] ADDR_CYCLE  = 8'hF3;

  // RAM covers 0x00..RAM_TOP inclusive
  localparam int RAM_BYTES = 240;

  // TX FIFO sizing: depth is a fixed power of two
  localparam int TX_DEPTH = 4;
  localparam int TX_PTR_W = 2;
  localparam int TX_CNT_W = 3;

  // STATUS register bit positions
  localparam int STATUS_FULL     = 0;
  localparam int STATUS_EMPTY    = 1;
  localparam int STATUS_OVERFLOW = 2;
  localparam int STATUS_COUNT_LO = 3;

  // Decoded target of a bus access
  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_GPIO,
    REGION_TXDATA,
    REGION_STATUS,
    REGION_CYCLE,
    REGION_NONE
  } region_e;

  // Map a byte address onto the region it selects; unmapped space is REGION_NONE
  function automatic region_e decode_addr(input logic [7:0] addr);
    region_e r;
    r = REGION_NONE;
    if (addr <= RAM_TOP)          r = REGION_RAM;
    else if (addr == ADDR_GPIO)   r = REGION_GPIO;
    else if (addr == ADDR_TXDATA) r = REGION_TXDATA;
    else if (addr == ADDR_STATUS) r = REGION_STATUS;
    else if (addr == ADDR_CYCLE)  r = REGION_CYCLE;
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: byte-wide memory port between the core's MA/WB stages and
// the data-memory slave. The core drives the request in MA and samples
// mem_r in WB, one cycle later.
interface dmem_mmio_if;

  logic       breq;
  logic [7:0] mem_rw_addr;
  logic [7:0] mem_w;
  logic       mem_w_en;
  logic [7:0] mem_r;

  // Core side: issues requests, receives registered read data
  modport master (
    output breq,
    output mem_rw_addr,
    output mem_w,
    output mem_w_en,
    input  mem_r
  );

  // Memory side: accepts requests, returns registered read data
  modport slave (
    input  breq,
    input  mem_rw_addr,
    input  mem_w,
    input  mem_w_en,
    output mem_r
  );

endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// tx_fifo: small circular byte FIFO feeding the TX valid/ready stream.
// A push into a full FIFO is only taken when a pop frees a slot in the same
// cycle; otherwise it is dropped here and the owner records the overflow.
module tx_fifo
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH = TX_DEPTH,
  parameter int PTR_W = TX_PTR_W,
  parameter int CNT_W = TX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       head
);

  logic [7:0]       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 8'h00 : slots[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage; stale slots are harmless because head is masked when empty
  always_ff @(posedge clk) begin
    if (!rst && do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: 240-byte data RAM plus MMIO window (GPIO, TX FIFO, STATUS and
// an optional free-running cycle counter). Read data is registered and
// returned one cycle after the request. Optional feature macro:
// DMEM_MMIO_CYCLE_EN enables the CYCLE counter at 0xF3; without it the
// address reads as zero and ignores writes.
module dmem_mmio
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dmem_mmio_if.slave  bus,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [7:0]          ram [RAM_BYTES];
  region_e             region;
  logic                rd_req;
  logic                wr_req;
  logic [7:0]          rd_val;
  logic [7:0]          mem_r_q;
  logic [7:0]          gpio_q;
  logic                overflow;
  logic [7:0]          status;
  logic [7:0]          cycle_val;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TX_CNT_W-1:0] fifo_count;
  logic [7:0]          fifo_head;
  logic                push_rejected;

  assign region = decode_addr(bus.mem_rw_addr);
  assign rd_req = bus.breq & ~bus.mem_w_en;
  assign wr_req = bus.breq &  bus.mem_w_en;

  assign fifo_push     = wr_req & (region == REGION_TXDATA);
  assign fifo_pop      = tx_valid & tx_ready;
  assign push_rejected = fifo_push & fifo_full & ~fifo_pop;

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_head;
  assign gpio_out = gpio_q;
  assign bus.mem_r = mem_r_q;

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .PTR_W (TX_PTR_W),
    .CNT_W (TX_CNT_W)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.mem_w),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Assemble STATUS from the live FIFO flags and the sticky overflow bit
  always_comb begin
    status = '0;
    status[STATUS_FULL]     = fifo_full;
    status[STATUS_EMPTY]    = fifo_empty;
    status[STATUS_OVERFLOW] = overflow;
    status[STATUS_COUNT_LO +: TX_CNT_W] = fifo_count;
  end

`ifdef DMEM_MMIO_CYCLE_EN
  logic [7:0] cycle_q;

  // Free-running counter; a CYCLE write replaces this cycle's increment
  always_ff @(posedge clk) begin
    if (rst)
      cycle_q <= 8'h00;
    else if (wr_req && region == REGION_CYCLE)
      cycle_q <= bus.mem_w;
    else
      cycle_q <= cycle_q + 8'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = 8'h00;
`endif

  // RAM is deliberately left out of reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (!rst && wr_req && region == REGION_RAM)
      ram[bus.mem_rw_addr] <= bus.mem_w;
  end

  // GPIO output register
  always_ff @(posedge clk) begin
    if (rst)
      gpio_q <= 8'h00;
    else if (wr_req && region == REGION_GPIO)
      gpio_q <= bus.mem_w;
  end

  // Sticky overflow: set by a dropped push, cleared by any STATUS write
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (wr_req && region == REGION_STATUS)
      overflow <= 1'b0;
    else if (push_rejected)
      overflow <= 1'b1;
  end

  // Read mux over pre-edge state; unmapped and write-only addresses read zero
  always_comb begin
    rd_val = 8'h00;
    case (region)
      REGION_RAM:    rd_val = ram[bus.mem_rw_addr];
      REGION_GPIO:   rd_val = gpio_q;
      REGION_TXDATA: rd_val = 8'h00;
      REGION_STATUS: rd_val = status;
      REGION_CYCLE:  rd_val = cycle_val;
      default:       rd_val = 8'h00;
    endcase
  end

  // Registered read data, held across every non-read cycle for the WB stage
  always_ff @(posedge clk) begin
    if (rst)
      mem_r_q <= 8'h00;
    else if (rd_req)
      mem_r_q <= rd_val;
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed scenarios plus randomized traffic for dmem_mmio,
// checked against a behavioural model built from arrays and a byte queue.
module tb_dmem_mmio;

  logic clk;
  logic rst;
  logic tx_ready;
  logic [7:0] gpio_out;
  logic [7:0] tx_data;
  logic tx_valid;

  dmem_mmio_if bus_if ();

  dmem_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Reference model state
  logic [7:0] ram_m [256];
  logic [7:0] gpio_m;
  logic [7:0] mem_r_m;
  logic [7:0] cyc_m;
  bit         ovf_m;
  logic [7:0] q_m [$];

  int tests;
  int fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, report any mismatch
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Model read value for an address, from pre-edge model state
  function automatic logic [7:0] modelRead(input logic [7:0] addr);
    int sz;
    sz = q_m.size();
    if (addr <= 8'hEF) return ram_m[addr];
    if (addr == 8'hF0) return gpio_m;
    if (addr == 8'hF2) return 8'(sz * 8 + (ovf_m ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == 4 ? 1 : 0));
`ifdef DMEM_MMIO_CYCLE_EN
    if (addr == 8'hF3) return cyc_m;
`endif
    return 8'h00;
  endfunction

  // Drive one cycle, advance the model across the edge, then compare outputs
  task automatic applyStimulus(input bit do_rst, input bit breq, input bit wen,
                               input logic [7:0] addr, input logic [7:0] wdata, input bit ready);
    int  sz;
    bit  pop;
    bit  accept;
    logic [7:0] rd;
    @(negedge clk);
    rst                = do_rst;
    bus_if.breq        = breq;
    bus_if.mem_w_en    = wen;
    bus_if.mem_rw_addr = addr;
    bus_if.mem_w       = wdata;
    tx_ready           = ready;
    if (do_rst) begin
      mem_r_m = 8'h00;
      gpio_m  = 8'h00;
      ovf_m   = 1'b0;
      cyc_m   = 8'h00;
      q_m.delete();
    end else begin
      sz     = q_m.size();
      pop    = (sz != 0) && ready;
      rd     = modelRead(addr);
      accept = (sz < 4) || pop;
      cyc_m  = cyc_m + 8'd1;
      if (breq && !wen) mem_r_m = rd;
      if (pop) void'(q_m.pop_front());
      if (breq && wen) begin
        if (addr <= 8'hEF) ram_m[addr] = wdata;
        else if (addr == 8'hF0) gpio_m = wdata;
        else if (addr == 8'hF1) begin
          if (accept) q_m.push_back(wdata);
          else ovf_m = 1'b1;
        end
        else if (addr == 8'hF2) ovf_m = 1'b0;
`ifdef DMEM_MMIO_CYCLE_EN
        else if (addr == 8'hF3) cyc_m = wdata;
`endif
      end
    end
    @(posedge clk);
    #1;
    checkOutput("mem_r", bus_if.mem_r, mem_r_m);
    checkOutput("gpio_out", gpio_out, gpio_m);
    checkOutput("tx_valid", {7'b0, tx_valid}, {7'b0, q_m.size() != 0});
    checkOutput("tx_data", tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
  endtask

  logic [7:0] drain_a [4];
  logic [7:0] drain_b [4];

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    tx_ready = 1'b0;
    bus_if.breq = 1'b0;
    bus_if.mem_w_en = 1'b0;
    bus_if.mem_rw_addr = 8'h00;
    bus_if.mem_w = 8'h00;
    for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;
    drain_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain_b = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

    // Reset state
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("rst_mem_r", bus_if.mem_r, 8'h00);
    checkOutput("rst_gpio", gpio_out, 8'h00);
    checkOutput("rst_tx_valid", {7'b0, tx_valid}, 8'h00);

    // Give every RAM byte a known value
    for (int a = 0; a < 240; a++)
      applyStimulus(0, 1, 1, 8'(a), 8'($urandom_range(255, 0)), 0);

    // RAM read-back, including the top byte
    applyStimulus(0, 1, 1, 8'h10, 8'h5A, 0);
    applyStimulus(0, 1, 0, 8'h10, 8'h00, 0);
    checkOutput("ram_10", bus_if.mem_r, 8'h5A);
    applyStimulus(0, 1, 1, 8'hEF, 8'hC3, 0);
    applyStimulus(0, 1, 0, 8'hEF, 8'h00, 0);
    checkOutput("ram_ef", bus_if.mem_r, 8'hC3);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
    checkOutput("mem_r_hold", bus_if.mem_r, 8'hC3);

    // GPIO write/read, then reset clears it
    applyStimulus(0, 1, 1, 8'hF0, 8'h81, 0);
    checkOutput("gpio_wr", gpio_out, 8'h81);
    applyStimulus(0, 1, 0, 8'hF0, 8'h00, 0);
    checkOutput("gpio_rd", bus_if.mem_r, 8'h81);
    applyStimulus(1, 1, 1, 8'hF0, 8'h99, 0);
    checkOutput("gpio_rst", gpio_out, 8'h00);
    checkOutput("mem_r_rst", bus_if.mem_r, 8'h00);

    // FIFO fill past capacity, STATUS, drain, overflow clear
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 1, 8'hF1, 8'(8'h11 * (i + 1)), 0);
    applyStimulus(0, 1, 0, 8'hF2, 8'h00, 0);
    checkOutput("status_ovf_full", bus_if.mem_r, 8'h25);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_head", tx_data, drain_a[i]);
      applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    end
    checkOutput("drain_done", {7'b0, tx_valid}, 8'h00);
    applyStimulus(0, 1, 1, 8'hF2, 8'hFF, 0);
    applyStimulus(0, 1, 0, 8'hF2, 8'h00, 0);
    checkOutput("status_cleared", bus_if.mem_r, 8'h02);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 1, 8'hF1, 8'(8'hA1 + i), 0);
    checkOutput("full_head", tx_data, 8'hA1);
    applyStimulus(0, 1, 1, 8'hF1, 8'h66, 1);
    applyStimulus(0, 1, 0, 8'hF2, 8'h00, 0);
    checkOutput("status_push_pop", bus_if.mem_r, 8'h21);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain2_head", tx_data, drain_b[i]);
      applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    end
    checkOutput("drain2_done", {7'b0, tx_valid}, 8'h00);

    // Cycle counter wrap, or inert register when not built
`ifdef DMEM_MMIO_CYCLE_EN
    applyStimulus(0, 1, 1, 8'hF3, 8'hFE, 0);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'hF3, 8'h00, 0);
    checkOutput("cycle_wrap", bus_if.mem_r, 8'h00);
`else
    applyStimulus(0, 1, 1, 8'hF3, 8'h5C, 0);
    applyStimulus(0, 1, 0, 8'hF3, 8'h00, 0);
    checkOutput("cycle_absent", bus_if.mem_r, 8'h00);
`endif
    applyStimulus(0, 1, 0, 8'hF8, 8'h00, 0);
    checkOutput("unmapped_rd", bus_if.mem_r, 8'h00);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 1, 8'hF1, 8'(8'h70 + i), 0);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1);
    checkOutput("rst_drain_valid", {7'b0, tx_valid}, 8'h00);
    checkOutput("rst_drain_data", tx_data, 8'h00);
    applyStimulus(0, 1, 0, 8'hF2, 8'h00, 1);
    checkOutput("rst_status", bus_if.mem_r, 8'h02);
    applyStimulus(0, 1, 0, 8'h10, 8'h00, 1);
    checkOutput("ram_keep", bus_if.mem_r, 8'h5A);

    // Randomized traffic, biased toward the MMIO window
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] addr;
      if ($urandom_range(1, 0) == 1)
        addr = 8'(8'hF0 + $urandom_range(4, 0) * ($urandom_range(3, 0) == 0 ? 3 : 1));
      else
        addr = 8'($urandom_range(255, 0));
      applyStimulus($urandom_range(299, 0) == 0,
                    $urandom_range(9, 0) < 8,
                    $urandom_range(1, 0) == 1,
                    addr,
                    8'($urandom_range(255, 0)),
                    $urandom_range(2, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory slave attached to the core's MA/WB memory port: 240-byte RAM plus a memory-mapped I/O window (GPIO output register, 4-entry TX FIFO with valid/ready drain, free-running cycle counter). Accepts one byte access per cycle in the core's MA stage. Read data is registered and returned in the following cycle, when the core's WB stage samples it.

## Interface
Parameters:
- TX_DEPTH, 4, TX FIFO entries; fixed power of two, pointer width 2, count width 3.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- breq  in  1  access request this cycle; no access when low.
- mem_rw_addr  in  8  byte address of the access.
- mem_w  in  8  write data.
- mem_w_en  in  1  1 = write, 0 = read; ignored unless breq=1.
- mem_r  out  8  registered read data.
- gpio_out  out  8  GPIO output register.
- tx_data  out  8  FIFO head byte; 0 when FIFO empty.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head this cycle.

## Operation
Address map:
- 0x00-0xEF RAM: read/write; contents are not reset.
- 0xF0 GPIO: read/write; reset value 0.
- 0xF1 TXDATA: a write pushes mem_w into the FIFO; a read returns 0.
- 0xF2 STATUS: read returns {2'b0, count[2:0], overflow, empty, full}, with bit0 = full. A write of any value clears overflow.
- 0xF3 CYCLE: read returns the counter value; a write loads mem_w into the counter.
- 0xF4-0xFF: reads return 0; writes are ignored.

Read and write behaviour:
- Read (breq=1, mem_w_en=0): mem_r <= selected value at the edge. mem_r holds its value on every non-read cycle.
- Read values are pre-edge state. Example: a STATUS read in the same cycle as a push reports the count before that push.

TX FIFO:
- tx_valid = (count != 0).
- pop = tx_valid & tx_ready.
- push = TXDATA write, accepted if count < 4 or pop occurs in the same cycle.
- A rejected push sets overflow (sticky) and drops the data.
- Simultaneous push and pop leave count unchanged.
- Pointers wrap modulo 4.

Cycle counter:
- Increments every cycle and wraps 0xFF -> 0x00.
- A write to CYCLE takes priority over the increment for that cycle.
- The counter is 8-bit unsigned.

Reset (rst=1 at an edge):
- mem_r=0, gpio_out=0, FIFO flushed (tx_valid=0, tx_data=0), overflow=0, counter=0.
- RAM contents are preserved.
- A reset in the middle of a drain discards every pending byte.
- Any access presented in the reset cycle is ignored.

## Timing
- Read latency is 1 cycle: address presented at edge N, mem_r valid after edge N, held until the next read.
- Write latency is 1 cycle: written state is visible to a read presented at edge N+1.
- Back-to-back read-after-write to the same address returns the new data.
- tx_valid/tx_data change only at edges: first byte visible 1 cycle after its push.
- Pop takes effect at the edge where tx_valid & tx_ready; the next head appears after that edge.
- Sustained throughput is 1 byte/cycle with tx_ready held high.

## Configuration
- DMEM_MMIO_CYCLE_EN defined: CYCLE register is implemented as above.
- Not defined: no counter flops; 0xF3 reads 0; writes to 0xF3 are ignored.

## Structure
- Package dmem_mmio_pkg holds:
  - address constants ADDR_GPIO=0xF0, ADDR_TXDATA=0xF1, ADDR_STATUS=0xF2, ADDR_CYCLE=0xF3, RAM_TOP=0xEF;
  - TX_DEPTH;
  - STATUS bit indices.
- One sub-module, tx_fifo. Interface: push, push_data, pop, full, empty, count, head; flushed by rst.
- Address decode, RAM, GPIO, counter and read mux live in dmem_mmio.

## Test plan
- RAM: write 0x5A to 0x10, read 0x10 next cycle -> mem_r=0x5A one cycle later. Read 0xEF after writing 0xC3 there -> 0xC3.
- GPIO: write 0x81 to 0xF0 -> gpio_out=0x81 after the edge; read 0xF0 -> 0x81. Assert rst -> gpio_out=0, mem_r=0.
- FIFO fill/overflow, tx_ready=0:
  - push 0x11, 0x22, 0x33, 0x44, 0x55;
  - STATUS read -> 0x25 (count=4, overflow, full);
  - drain with tx_ready=1 -> tx_data sequence 0x11, 0x22, 0x33, 0x44, then tx_valid=0;
  - write 0xF2 -> overflow cleared.
- Full with simultaneous push and pop: with FIFO full and tx_ready=1, push 0x66 -> no overflow, count stays 4, 0x66 emerges fifth.
- CYCLE (macro defined): write 0xFE, read two cycles later -> 0x00 (wrap). Macro undefined: read 0xF3 -> 0.
- Reset mid-drain: 3 bytes queued, assert rst -> tx_valid=0, STATUS=0x02; RAM byte written earlier still reads back.
